vc_fifo_bank: RTL

Four-channel virtual-channel input buffer that sits directly upstream of the QoS weighted arbiter. It accepts 4-bit data words tagged with a virtual-channel number, stores them in one of four independent circular FIFOs, and hands a word to the arbiter from whichever VC the arbiter selects. Per-VC empty, full, pause and continue status, plus sticky error flags, feed the arbiter's control state machine.

---
 rtl/vc_fifo_bank_if.sv | 27 ++
 rtl/vc_fifo_bank.sv | 106 ++++++++++
 2 files changed

// File: rtl/vc_fifo_bank_if.sv
// rtl/vc_fifo_bank_if.sv - write/read/status bundle between a VC source/arbiter and the VC FIFO bank
interface vc_fifo_bank_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] Data_Word;
    logic [1:0]        vc_assign;
    logic              push;
    logic [1:0]        VC_id;
    logic              pop;
    logic [DATA_W-1:0] Data_Out;
    logic              valid_out;
    logic [3:0]        sEmpty;
    logic [3:0]        sFull;
    logic [3:0]        sPause;
    logic [3:0]        sContinue;
    logic [3:0]        oError;

    modport master (
        output Data_Word, vc_assign, push, VC_id, pop,
        input  Data_Out, valid_out, sEmpty, sFull, sPause, sContinue, oError
    );

    modport slave (
        input  Data_Word, vc_assign, push, VC_id, pop,
        output Data_Out, valid_out, sEmpty, sFull, sPause, sContinue, oError
    );
endinterface

// File: rtl/vc_fifo_bank.sv
// rtl/vc_fifo_bank.sv - four independent circular FIFOs with per-VC status for the QoS arbiter
module vc_fifo_bank #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 8,
    parameter int PAUSE_TH = 6,
    parameter int CONT_TH  = 2
) (
    input  logic              CLK_2MHz,
    input  logic              reset,
    vc_fifo_bank_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PAUSE_C = CW'(PAUSE_TH);
    localparam logic [CW-1:0] CONT_C  = CW'(CONT_TH);

    logic [DATA_W-1:0] mem [4][DEPTH];
    logic [PW-1:0]     wr_ptr [4];
    logic [PW-1:0]     rd_ptr [4];
    logic [CW-1:0]     count [4];
    logic [CW-1:0]     count_nxt [4];
    logic [3:0]        push_ok;
    logic [3:0]        pop_ok;
    logic [3:0]        err_set;
    logic [3:0]        pause_nxt;
    logic [3:0]        pause_clr;

    // Per-VC accept/reject decisions; a pop on a full VC frees the slot the push needs
    always_comb begin
        push_ok = 4'h0;
        pop_ok  = 4'h0;
        err_set = 4'h0;
        pause_nxt = 4'h0;
        for (int v = 0; v < 4; v++) begin
            logic push_sel;
            logic pop_sel;
            push_sel = bus.push && (bus.vc_assign == 2'(v));
            pop_sel  = bus.pop && (bus.VC_id == 2'(v));
            pop_ok[v]  = pop_sel && (count[v] != '0);
            push_ok[v] = push_sel && ((count[v] != FULL_C) || pop_ok[v]);
            err_set[v] = (push_sel && !push_ok[v]) || (pop_sel && (count[v] == '0));
            count_nxt[v] = count[v] + CW'(push_ok[v]) - CW'(pop_ok[v]);
            if (count_nxt[v] >= PAUSE_C) begin
                pause_nxt[v] = 1'b1;
            end else if (count_nxt[v] <= CONT_C) begin
                pause_nxt[v] = 1'b0;
            end else begin
                pause_nxt[v] = bus.sPause[v];
            end
        end
    end

    // Empty/full flags decode straight from the registered occupancy
    always_comb begin
        for (int v = 0; v < 4; v++) begin
            bus.sEmpty[v] = (count[v] == '0);
            bus.sFull[v]  = (count[v] == FULL_C);
        end
    end

    // Storage write port; contents need no reset because pointers are cleared
    always_ff @(posedge CLK_2MHz) begin
        for (int v = 0; v < 4; v++) begin
            if (!reset && push_ok[v]) begin
                mem[v][wr_ptr[v]] <= bus.Data_Word;
            end
        end
    end

    // Pointers, occupancy, pause hysteresis, release strobe, sticky errors, read data
    always_ff @(posedge CLK_2MHz) begin
        if (reset) begin
            for (int v = 0; v < 4; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
            bus.sPause    <= 4'h0;
            pause_clr     <= 4'h0;
            bus.sContinue <= 4'h0;
            bus.oError    <= 4'h0;
            bus.Data_Out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            for (int v = 0; v < 4; v++) begin
                if (push_ok[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PW'(1);
                end
                if (pop_ok[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PW'(1);
                end
                count[v] <= count_nxt[v];
            end
            bus.sPause    <= pause_nxt;
            // Release is remembered for one cycle so the strobe lands after sPause drops
            pause_clr     <= bus.sPause & ~pause_nxt;
            bus.sContinue <= pause_clr;
            bus.oError    <= bus.oError | err_set;
            bus.valid_out <= |pop_ok;
            if (|pop_ok) begin
                bus.Data_Out <= mem[bus.VC_id][rd_ptr[bus.VC_id]];
            end
        end
    end
endmodule
